// File: rtl/aes_pkg.sv
// Shared AES datapath constants, S-box sharing FSM states and requester ids.
package aes_pkg;

    localparam int unsigned AES_BYTE_W = 8;
    localparam int unsigned SB_BYTES   = 16;
    localparam int unsigned KX_BYTES   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } sbox_state_e;

    typedef enum logic {
        ReqSb = 1'b0,
        ReqKx = 1'b1
    } req_id_e;

endpackage

// File: rtl/sbox_rr_arb.sv
// Two-way round-robin arbiter between SubBytes and key expansion for the shared S-box.
module sbox_rr_arb
    import aes_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  logic    sb_req,
    input  logic    kx_req,
    output logic    grant,
    output req_id_e grant_id
);

    req_id_e last_grant_q;

    always_comb begin
        grant = en && (sb_req || kx_req);
        // On a tie the requester that did not win last time goes first.
        if (sb_req && kx_req) begin
            grant_id = (last_grant_q == ReqSb) ? ReqKx : ReqSb;
        end else if (kx_req) begin
            grant_id = ReqKx;
        end else begin
            grant_id = ReqSb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= ReqSb;
        end else if (grant) begin
            last_grant_q <= grant_id;
        end
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares one byte-wide S-box ROM between SubBytes (16 bytes) and SubWord (4 bytes),
// streaming one address per cycle and returning the substituted word with a done pulse.
module sbox_share_ctrl #(
    parameter int unsigned SB_BYTES = aes_pkg::SB_BYTES,
    parameter int unsigned KX_BYTES = aes_pkg::KX_BYTES,
    parameter int unsigned SBOX_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sb_req,
    input  logic [8*SB_BYTES-1:0] sb_state_in,
    output logic                  sb_done,
    output logic [8*SB_BYTES-1:0] sb_state_out,
    input  logic                  kx_req,
    input  logic [8*KX_BYTES-1:0] kx_word_in,
    output logic                  kx_done,
    output logic [8*KX_BYTES-1:0] kx_word_out,
    output logic                  busy,
    output logic [7:0]            sbox_addr,
    output logic                  sbox_chip_en,
    output logic                  sbox_read_en,
    input  logic [7:0]            sbox_data
);

    import aes_pkg::*;

    localparam int unsigned SbW  = AES_BYTE_W * SB_BYTES;
    localparam int unsigned KxW  = AES_BYTE_W * KX_BYTES;
    localparam int unsigned IdxW = $clog2(SB_BYTES);
    localparam logic [IdxW-1:0] SbLast = IdxW'(SB_BYTES - 1);
    localparam logic [IdxW-1:0] KxLast = IdxW'(KX_BYTES - 1);

    sbox_state_e     state_q, state_d;
    req_id_e         owner_q;
    req_id_e         grant_id;
    logic            grant;
    logic [SbW-1:0]  op_q, buf_q, sb_out_q, cap_word;
    logic [KxW-1:0]  kx_out_q;
    logic [IdxW-1:0] iss_cnt_q, cap_cnt_q, owner_last;
    logic            sb_done_q, kx_done_q;
    logic            issuing, iss_last, cap_valid, cap_last;

    sbox_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == StIdle),
        .sb_req   (sb_req),
        .kx_req   (kx_req),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign owner_last = (owner_q == ReqSb) ? SbLast : KxLast;
    assign issuing    = (state_q == StIssue);
    assign iss_last   = issuing && (iss_cnt_q == owner_last);
    assign cap_last   = cap_valid && (cap_cnt_q == owner_last);

    // Capture strobe trails the address strobe by the ROM latency.
    if (SBOX_LAT == 0) begin : g_lat0
        assign cap_valid = issuing;
    end else begin : g_lat
        logic [SBOX_LAT-1:0] pipe_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q[0] <= issuing;
                for (int i = 1; i < int'(SBOX_LAT); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
        assign cap_valid = pipe_q[SBOX_LAT-1];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StIssue;
            StIssue: if (iss_last) state_d = (SBOX_LAT == 0) ? StIdle : StDrain;
            StDrain: if (cap_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cap_word = buf_q;
        cap_word[32'(cap_cnt_q) * AES_BYTE_W +: AES_BYTE_W] = sbox_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= ReqSb;
            op_q      <= '0;
            buf_q     <= '0;
            sb_out_q  <= '0;
            kx_out_q  <= '0;
            iss_cnt_q <= '0;
            cap_cnt_q <= '0;
            sb_done_q <= 1'b0;
            kx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sb_done_q <= 1'b0;
            kx_done_q <= 1'b0;
            if (grant) begin
                owner_q <= grant_id;
                op_q    <= (grant_id == ReqSb) ? sb_state_in : SbW'(kx_word_in);
            end
            if (issuing) begin
                iss_cnt_q <= iss_last ? '0 : iss_cnt_q + 1'b1;
            end
            if (cap_valid) begin
                buf_q     <= cap_word;
                cap_cnt_q <= cap_last ? '0 : cap_cnt_q + 1'b1;
                if (cap_last && owner_q == ReqSb) begin
                    sb_out_q  <= cap_word;
                    sb_done_q <= 1'b1;
                end else if (cap_last) begin
                    kx_out_q  <= cap_word[KxW-1:0];
                    kx_done_q <= 1'b1;
                end
            end
        end
    end

    assign sb_done      = sb_done_q;
    assign kx_done      = kx_done_q;
    assign sb_state_out = sb_out_q;
    assign kx_word_out  = kx_out_q;
    assign busy         = (state_q != StIdle);
    assign sbox_addr    = issuing ? op_q[32'(iss_cnt_q) * AES_BYTE_W +: AES_BYTE_W] : 8'h00;
    assign sbox_chip_en = issuing;
    assign sbox_read_en = issuing;

endmodule
